frog_move_ctrl: RTL and testbench
=================================

// Module: frog_move_ctrl
// PURPOSE
//  Converts NIOS USB keycodes into discrete frog hops, one per key press, paced by frame ticks.
//  Sits between the NIOS keycode PIO and frogger_game, replacing the free-running ball motion.
//  Owns frog position, facing, hop animation and death/respawn timing; frogger_game asserts hit.
// PARAMETERS
//  START_X     304  respawn / reset X (px, top-left of 16x16 frog)
//  START_Y     448  respawn / reset Y (px)
//  HOP_DIST    32   px moved per hop; must be an integer multiple of HOP_FRAMES
//  HOP_FRAMES  8    frames per hop animation; step = HOP_DIST/HOP_FRAMES px per frame
//  X_MIN/X_MAX 0/608   legal frog X range, inclusive
//  Y_MIN/Y_MAX 32/448  legal frog Y range, inclusive
//  DEAD_FRAMES 60   frames spent in DEAD before respawn
// PORTS
//  Clk        in   1   system clock (50 MHz)
//  Reset      in   1   synchronous, active-high reset
//  frame_clk  in   1   VGA_VS, asynchronous to game logic; rising edge = new frame
//  keycode    in   16  [7:0] first HID key, [15:8] second HID key; 0x00 = none
//  hit        in   1   collision/drown from frogger_game, level-sensitive, sampled every Clk
//  frog_x     out  10  frog X position (px)
//  frog_y     out  10  frog Y position (px)
//  frog_dir   out  2   facing: 0 UP, 1 DOWN, 2 LEFT, 3 RIGHT
//  hopping    out  1   high while in HOP
//  dead       out  1   high while in DEAD
//  hop_done   out  1   one-Clk pulse on the tick that completes a hop
// BEHAVIOUR
//  Reset: frog_x=START_X, frog_y=START_Y, frog_dir=UP, hopping=0, dead=0, hop_done=0, FSM=IDLE,
//   frame counter=0, prev-key register=none. Reset mid-hop or mid-DEAD aborts the hop or DEAD.
//  Frame tick: frame_clk passes through a 2-flop synchronizer plus an edge register.
//   tick is a 1-Clk pulse, 3 Clk after the frame_clk rise. All state updates occur only on tick
//   except hit->DEAD and Reset. Outputs change on the Clk edge after tick is high.
//  Key decode, evaluated once per tick: UP=0x1A/0x52, LEFT=0x04/0x50, DOWN=0x16/0x51, RIGHT=0x07/0x4F.
//   Byte [7:0] is decoded first; [15:8] is used only if [7:0] decodes to none.
//   Unknown codes decode to none. The decoded direction is stored in a prev-key register each tick.
//  New press: decoded dir != none AND (prev-key == none OR prev-key != dir).
//   A held key yields exactly one hop. Changing directly to another direction counts as a new press.
//  FSM IDLE: on tick with a new press, set frog_dir=dir. If target (pos +/- HOP_DIST) stays within
//   [MIN,MAX], go to HOP with cnt=0. Otherwise stay in IDLE (facing still updates).
//  FSM HOP: each tick, move step px in frog_dir and increment cnt. On the tick where cnt reaches
//   HOP_FRAMES-1, make the final move, pulse hop_done and return to IDLE.
//   Key presses during HOP are ignored (no buffering). prev-key still updates.
//  FSM DEAD: entered from IDLE or HOP on any Clk with hit=1. Position freezes and hopping=0.
//   After DEAD_FRAMES ticks, set frog_x/y=START_X/Y, frog_dir=UP and go to IDLE.
//   hit is ignored while in DEAD.
//  Simultaneous events: Reset > hit > tick. hit on the completing tick means DEAD, with no hop_done.
//  Arithmetic: 10-bit unsigned. Bounds are checked on the hop target before moving, so there is no
//   wrap or clamp mid-hop.
// STRUCTURE
//  frogger_pkg: dir_t enum {UP,DOWN,LEFT,RIGHT}, move_state_t {IDLE,HOP,DEAD}, HID keycode localparams.
//   frogger_game and color_mapper reuse these.
//  Sub-module frame_tick_sync: synchronizer + rising-edge pulse. Instanced once here; also
//   reusable for lane scrollers.
//  Remainder in this file: key decode/edge logic (comb), FSM + counters + position regs (always_ff).
// TESTING
//  1 Reset held 2 Clk, any keycode -> frog_x=304, frog_y=448, dir=UP, hopping=dead=hop_done=0.
//  2 keycode=0x001A held 20 ticks -> one hop: y=444,440..416 over ticks 1-8, a single hop_done,
//    no further motion.
//  3 frog_x=0, keycode=0x0004 -> stays IDLE, frog_x=0, frog_dir=LEFT, no hop_done.
//  4 hit pulsed 1 Clk at HOP cnt=3 -> dead=1, position frozen; 60 ticks later x=304, y=448,
//    dead=0, dir=UP.
//  5 keycode=0x0704 -> LEFT wins (low byte); then 0x0007 next tick -> new press RIGHT after the
//    hop ends only if still held as new (expect ignored during HOP).
//  6 Reset asserted at HOP cnt=5 -> next Clk at start position, IDLE; frame_clk jitter never
//    yields two ticks per frame.

Source files
------------

// File: rtl/frogger_pkg.sv
// frogger_pkg: shared types and constants for the frogger game blocks.
//   dir_t        : frog facing / hop direction (0 UP, 1 DOWN, 2 LEFT, 3 RIGHT)
//   move_state_t : frog movement FSM states
//   key_dec_t    : decoded keycode (valid flag + direction)
//   KEY_*        : USB HID keycodes for WASD and arrow keys
//   decode_key   : maps one HID keycode byte to a key_dec_t
package frogger_pkg;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOP  = 2'd1,
        DEAD = 2'd2
    } move_state_t;

    typedef struct packed {
        logic valid;
        dir_t dir;
    } key_dec_t;

    localparam logic [7:0] KEY_NONE        = 8'h00;
    localparam logic [7:0] KEY_W           = 8'h1A;
    localparam logic [7:0] KEY_A           = 8'h04;
    localparam logic [7:0] KEY_S           = 8'h16;
    localparam logic [7:0] KEY_D           = 8'h07;
    localparam logic [7:0] KEY_UP_ARROW    = 8'h52;
    localparam logic [7:0] KEY_LEFT_ARROW  = 8'h50;
    localparam logic [7:0] KEY_DOWN_ARROW  = 8'h51;
    localparam logic [7:0] KEY_RIGHT_ARROW = 8'h4F;

    // Unknown codes (including KEY_NONE) come back with valid = 0.
    function automatic key_dec_t decode_key(input logic [7:0] code);
        key_dec_t res;
        res.valid = 1'b1;
        res.dir   = UP;
        case (code)
            KEY_W, KEY_UP_ARROW:       res.dir = UP;
            KEY_S, KEY_DOWN_ARROW:     res.dir = DOWN;
            KEY_A, KEY_LEFT_ARROW:     res.dir = LEFT;
            KEY_D, KEY_RIGHT_ARROW:    res.dir = RIGHT;
            default:                   res.valid = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/frame_tick_sync.sv
// frame_tick_sync: brings an asynchronous frame strobe (VGA_VS) into the Clk domain and
// produces a single-Clk pulse per rising edge.
//   Clk      in  system clock
//   Reset    in  synchronous, active-high reset
//   async_in in  asynchronous level (e.g. VGA_VS)
//   tick     out registered 1-Clk pulse, 3 Clk after the async_in rise
module frame_tick_sync (
    input  logic Clk,
    input  logic Reset,
    input  logic async_in,
    output logic tick
);

    logic sync1, sync2, sync_prev;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            sync_prev <= 1'b0;
            tick      <= 1'b0;
        end else begin
            sync1     <= async_in;
            sync2     <= sync1;
            sync_prev <= sync2;
            // Edge detect on the synchronized level only, so input glitches between
            // Clk edges can never produce a second pulse for one frame.
            tick      <= sync2 & ~sync_prev;
        end
    end

endmodule

// File: rtl/frog_move_ctrl.sv
// frog_move_ctrl: turns NIOS USB keycodes into discrete frog hops, paced by frame ticks.
// Owns frog position, facing, hop animation and death/respawn timing.
//   Clk       in  system clock
//   Reset     in  synchronous, active-high reset
//   frame_clk in  VGA_VS, asynchronous; rising edge = new frame
//   keycode   in  [7:0] first HID key, [15:8] second HID key; 0x00 = none
//   hit       in  collision/drown, level-sensitive, sampled every Clk
//   frog_x    out frog X position (px, top-left)
//   frog_y    out frog Y position (px, top-left)
//   frog_dir  out facing: 0 UP, 1 DOWN, 2 LEFT, 3 RIGHT
//   hopping   out high while hopping
//   dead      out high while dead
//   hop_done  out 1-Clk pulse when a hop completes
module frog_move_ctrl #(
    parameter int unsigned START_X     = 304,
    parameter int unsigned START_Y     = 448,
    parameter int unsigned HOP_DIST    = 32,
    parameter int unsigned HOP_FRAMES  = 8,
    parameter int unsigned X_MIN       = 0,
    parameter int unsigned X_MAX       = 608,
    parameter int unsigned Y_MIN       = 32,
    parameter int unsigned Y_MAX       = 448,
    parameter int unsigned DEAD_FRAMES = 60
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic [15:0] keycode,
    input  logic        hit,
    output logic [9:0]  frog_x,
    output logic [9:0]  frog_y,
    output logic [1:0]  frog_dir,
    output logic        hopping,
    output logic        dead,
    output logic        hop_done
);

    import frogger_pkg::*;

    localparam int unsigned CntMax = (DEAD_FRAMES > HOP_FRAMES) ? DEAD_FRAMES : HOP_FRAMES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    localparam logic [9:0]      StartX   = 10'(START_X);
    localparam logic [9:0]      StartY   = 10'(START_Y);
    localparam logic [9:0]      Step     = 10'(HOP_DIST / HOP_FRAMES);
    localparam logic [10:0]     Hop11    = 11'(HOP_DIST);
    localparam logic [10:0]     XMin11   = 11'(X_MIN);
    localparam logic [10:0]     XMax11   = 11'(X_MAX);
    localparam logic [10:0]     YMin11   = 11'(Y_MIN);
    localparam logic [10:0]     YMax11   = 11'(Y_MAX);
    localparam logic [CntW-1:0] HopLast  = CntW'(HOP_FRAMES - 1);
    localparam logic [CntW-1:0] DeadLast = CntW'(DEAD_FRAMES - 1);

    logic tick;

    frame_tick_sync u_frame_tick_sync (
        .Clk      (Clk),
        .Reset    (Reset),
        .async_in (frame_clk),
        .tick     (tick)
    );

    move_state_t     state;
    dir_t            dir_q;
    logic [CntW-1:0] cnt;
    logic [CntW-1:0] cnt_inc;
    logic            prev_valid;
    dir_t            prev_dir;

    key_dec_t dec_lo, dec_hi, dec;
    logic     new_press;
    logic     in_bounds;
    dir_t     move_dir;
    logic [9:0] next_x, next_y;

    assign frog_dir = dir_q;
    assign cnt_inc  = cnt + CntW'(1);

    // Key decode and press-edge detection; low byte has priority.
    always_comb begin
        dec_lo    = decode_key(keycode[7:0]);
        dec_hi    = decode_key(keycode[15:8]);
        dec       = dec_lo.valid ? dec_lo : dec_hi;
        new_press = dec.valid && (!prev_valid || (prev_dir != dec.dir));
    end

    // Bounds check on the full hop target, done in 11 bits so nothing can wrap.
    always_comb begin
        in_bounds = 1'b0;
        case (dec.dir)
            UP:    in_bounds = {1'b0, frog_y} >= (YMin11 + Hop11);
            DOWN:  in_bounds = ({1'b0, frog_y} + Hop11) <= YMax11;
            LEFT:  in_bounds = {1'b0, frog_x} >= (XMin11 + Hop11);
            RIGHT: in_bounds = ({1'b0, frog_x} + Hop11) <= XMax11;
            default: in_bounds = 1'b0;
        endcase
    end

    // One animation step; the first step is taken on the tick that starts the hop.
    always_comb begin
        move_dir = (state == IDLE) ? dec.dir : dir_q;
        next_x   = frog_x;
        next_y   = frog_y;
        case (move_dir)
            UP:    next_y = frog_y - Step;
            DOWN:  next_y = frog_y + Step;
            LEFT:  next_x = frog_x - Step;
            RIGHT: next_x = frog_x + Step;
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= IDLE;
            frog_x     <= StartX;
            frog_y     <= StartY;
            dir_q      <= UP;
            hopping    <= 1'b0;
            dead       <= 1'b0;
            hop_done   <= 1'b0;
            cnt        <= '0;
            prev_valid <= 1'b0;
            prev_dir   <= UP;
        end else begin
            hop_done <= 1'b0;

            if (tick) begin
                prev_valid <= dec.valid;
                prev_dir   <= dec.dir;
            end

            // hit outranks tick: a hit on the completing tick kills the hop_done pulse.
            if (hit && (state != DEAD)) begin
                state   <= DEAD;
                dead    <= 1'b1;
                hopping <= 1'b0;
                cnt     <= '0;
            end else if (tick) begin
                case (state)
                    IDLE: begin
                        if (new_press) begin
                            dir_q <= dec.dir;
                            if (in_bounds) begin
                                frog_x  <= next_x;
                                frog_y  <= next_y;
                                cnt     <= '0;
                                hopping <= 1'b1;
                                state   <= HOP;
                            end
                        end
                    end
                    HOP: begin
                        frog_x <= next_x;
                        frog_y <= next_y;
                        cnt    <= cnt_inc;
                        if (cnt_inc == HopLast) begin
                            hopping  <= 1'b0;
                            hop_done <= 1'b1;
                            state    <= IDLE;
                        end
                    end
                    DEAD: begin
                        if (cnt == DeadLast) begin
                            frog_x <= StartX;
                            frog_y <= StartY;
                            dir_q  <= UP;
                            dead   <= 1'b0;
                            cnt    <= '0;
                            state  <= IDLE;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_frog_move_ctrl.sv
// Bench for frog_move_ctrl: directed key/frame/hit stimulus. Expected hop_done, death and
// respawn events are queued by the stimulus and popped by a monitor as the DUT shows them;
// per-frame positions and idle-state values are compared directly.
module tb_frog_move_ctrl;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        frame_clk = 1'b0;
    logic [15:0] keycode = 16'h0000;
    logic        hit = 1'b0;
    logic [9:0]  frog_x, frog_y;
    logic [1:0]  frog_dir;
    logic        hopping, dead, hop_done;

    frog_move_ctrl dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .keycode   (keycode),
        .hit       (hit),
        .frog_x    (frog_x),
        .frog_y    (frog_y),
        .frog_dir  (frog_dir),
        .hopping   (hopping),
        .dead      (dead),
        .hop_done  (hop_done)
    );

    always #5 Clk = ~Clk;

    localparam int EvHopDone = 0;
    localparam int EvDeadIn  = 1;
    localparam int EvRespawn = 2;

    typedef struct {
        int kind;
        int x;
        int y;
        int dir;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    logic hd_prev = 1'b0;
    logic dead_prev = 1'b0;
    int   ex, ey;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input int kind, input int x, input int y, input int dir);
        exp_t e;
        e.kind = kind; e.x = x; e.y = y; e.dir = dir;
        sb.push_back(e);
    endtask

    task automatic sb_pop(input int kind);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got event %0d at x=%0d y=%0d, expected no event",
                     kind, frog_x, frog_y);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind || e.x != int'(frog_x) || e.y != int'(frog_y)
                || e.dir != int'(frog_dir)) begin
                errors++;
                $display("FAIL sb_event: got kind=%0d x=%0d y=%0d dir=%0d expected kind=%0d x=%0d y=%0d dir=%0d",
                         kind, frog_x, frog_y, frog_dir, e.kind, e.x, e.y, e.dir);
            end
        end
    endtask

    // Event monitor
    always @(negedge Clk) begin
        if (mon_en) begin
            if (hop_done && hd_prev) begin
                checks++;
                errors++;
                $display("FAIL hop_done_width: got 2+ cycle pulse expected 1 cycle");
            end
            if (hop_done && !hd_prev) sb_pop(EvHopDone);
            if (dead && !dead_prev)   sb_pop(EvDeadIn);
            if (!dead && dead_prev)   sb_pop(EvRespawn);
            hd_prev   = hop_done;
            dead_prev = dead;
        end
    end

    // One frame; outputs are settled on return. glitch adds a bounce on the rising edge.
    task automatic do_frame(input bit glitch);
        int unsigned d;
        @(negedge Clk);
        if (glitch) begin
            @(posedge Clk);
            #1 frame_clk = 1'b1;
            #2 frame_clk = 1'b0;
            #2 frame_clk = 1'b1;
        end else begin
            d = $urandom_range(1, 8);
            #(d) frame_clk = 1'b1;
        end
        repeat (5) @(posedge Clk);
        d = $urandom_range(1, 8);
        #(d) frame_clk = 1'b0;
        if (glitch) begin
            #1 frame_clk = 1'b1;
            #1 frame_clk = 1'b0;
        end
        repeat (5) @(posedge Clk);
        @(negedge Clk);
    endtask

    // Full hop in direction dir (0 UP,1 DOWN,2 LEFT,3 RIGHT), checked every frame.
    task automatic do_hop(input logic [15:0] kc, input int dir, input string name);
        int dx, dy;
        dx = (dir == 2) ? -4 : (dir == 3) ? 4 : 0;
        dy = (dir == 0) ? -4 : (dir == 1) ? 4 : 0;
        push(EvHopDone, ex + 8 * dx, ey + 8 * dy, dir);
        keycode = kc;
        for (int k = 1; k <= 8; k++) begin
            do_frame(1'b0);
            check({name, "_x"}, int'(frog_x), ex + k * dx);
            check({name, "_y"}, int'(frog_y), ey + k * dy);
            check({name, "_hopping"}, int'(hopping), (k < 8) ? 1 : 0);
        end
        ex = ex + 8 * dx;
        ey = ey + 8 * dy;
        keycode = 16'h0000;
        do_frame(1'b0);
    endtask

    initial begin
        // 1: reset with a key held
        keycode = 16'h001A;
        Reset   = 1'b1;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check("rst_x", int'(frog_x), 304);
        check("rst_y", int'(frog_y), 448);
        check("rst_dir", int'(frog_dir), 0);
        check("rst_hopping", int'(hopping), 0);
        check("rst_dead", int'(dead), 0);
        check("rst_hop_done", int'(hop_done), 0);
        keycode = 16'h0000;
        Reset   = 1'b0;
        hd_prev   = hop_done;
        dead_prev = dead;
        mon_en    = 1'b1;
        ex = 304;
        ey = 448;
        do_frame(1'b0);

        // Y_MAX boundary: DOWN at y=448 only turns the frog
        keycode = 16'h0016;
        do_frame(1'b0);
        check("ybound_y", int'(frog_y), 448);
        check("ybound_dir", int'(frog_dir), 1);
        check("ybound_hopping", int'(hopping), 0);
        keycode = 16'h0000;
        do_frame(1'b0);

        // 2: UP held for 20 frames -> exactly one hop
        push(EvHopDone, 304, 416, 0);
        keycode = 16'h001A;
        for (int k = 1; k <= 20; k++) begin
            do_frame(1'b0);
            check("held_y", int'(frog_y), (k <= 8) ? 448 - 4 * k : 416);
            check("held_hopping", int'(hopping), (k < 8) ? 1 : 0);
        end
        check("held_dir", int'(frog_dir), 0);
        ey = 416;
        keycode = 16'h0000;
        do_frame(1'b0);

        // 5: low byte wins; RIGHT during the hop is ignored and not replayed while held
        push(EvHopDone, 272, 416, 2);
        keycode = 16'h0704;
        do_frame(1'b0);
        check("prio_x", int'(frog_x), 300);
        check("prio_dir", int'(frog_dir), 2);
        keycode = 16'h0007;
        for (int k = 2; k <= 10; k++) do_frame(1'b0);
        check("ignored_x", int'(frog_x), 272);
        check("ignored_dir", int'(frog_dir), 2);
        check("ignored_hopping", int'(hopping), 0);
        ex = 272;
        keycode = 16'h0000;
        do_frame(1'b0);
        do_hop(16'h0007, 3, "right");
        check("right_dir", int'(frog_dir), 3);

        // High byte used when low byte is unknown
        do_hop(16'h1A33, 0, "hibyte");

        // 3: walk to the left edge, then a LEFT press only turns the frog
        do_hop(16'h0007, 3, "turn_right");
        for (int i = 0; i < 10; i++) do_hop(16'h0050, 2, "left_walk");
        check("edge_x", int'(frog_x), 16);
        do_hop(16'h0016, 1, "down");
        keycode = 16'h0004;
        do_frame(1'b0);
        check("xbound_x", int'(frog_x), 16);
        check("xbound_y", int'(frog_y), 416);
        check("xbound_dir", int'(frog_dir), 2);
        check("xbound_hopping", int'(hopping), 0);
        keycode = 16'h0000;
        do_frame(1'b0);

        // 4: hit at HOP cnt=3, hit ignored while dead, respawn after 60 frames
        keycode = 16'h0052;
        for (int k = 1; k <= 4; k++) do_frame(1'b0);
        check("prehit_y", int'(frog_y), 400);
        push(EvDeadIn, 16, 400, 0);
        hit = 1'b1;
        @(negedge Clk);
        hit = 1'b0;
        keycode = 16'h0000;
        @(negedge Clk);
        check("hit_dead", int'(dead), 1);
        check("hit_hopping", int'(hopping), 0);
        for (int k = 1; k <= 30; k++) do_frame(1'b0);
        hit = 1'b1;
        @(negedge Clk);
        hit = 1'b0;
        for (int k = 31; k <= 59; k++) do_frame(1'b0);
        check("dead59_dead", int'(dead), 1);
        check("dead59_y", int'(frog_y), 400);
        check("dead59_x", int'(frog_x), 16);
        push(EvRespawn, 304, 448, 0);
        do_frame(1'b0);
        check("respawn_dead", int'(dead), 0);
        check("respawn_x", int'(frog_x), 304);
        check("respawn_y", int'(frog_y), 448);
        check("respawn_dir", int'(frog_dir), 0);

        // 6: glitchy frame_clk still gives 4 px per frame; reset at HOP cnt=5 aborts
        keycode = 16'h001A;
        for (int k = 1; k <= 6; k++) begin
            do_frame(1'b1);
            check("glitch_y", int'(frog_y), 448 - 4 * k);
        end
        keycode = 16'h0000;
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        check("abort_x", int'(frog_x), 304);
        check("abort_y", int'(frog_y), 448);
        check("abort_hopping", int'(hopping), 0);
        check("abort_dir", int'(frog_dir), 0);
        for (int k = 0; k < 3; k++) do_frame(1'b1);
        check("abort_idle_y", int'(frog_y), 448);
        check("abort_idle_hopping", int'(hopping), 0);

        repeat (20) @(negedge Clk);
        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
